led_bus_ctrl: RTL and testbench



---
 rtl/led_bus_pkg.sv | 21 ++
 rtl/led_bus_if.sv | 10 +
 rtl/led_blink_timer.sv | 58 +++++
 rtl/led_bus_ctrl.sv | 107 ++++++++++
 tb/tb_led_bus_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/led_bus_pkg.sv
// Shared constants for the LED bus controller: register offsets, blink FSM encoding, defaults.
package led_bus_pkg;

  localparam int unsigned LED_BUS_W            = 8;
  localparam int unsigned LED_PERIOD_W         = 8;
  localparam int unsigned LED_TICK_DIV_DEFAULT = 100000;

  localparam logic [2:0] LED_OFF_LED_L   = 3'd0;
  localparam logic [2:0] LED_OFF_LED_H   = 3'd1;
  localparam logic [2:0] LED_OFF_BLINK_L = 3'd2;
  localparam logic [2:0] LED_OFF_BLINK_H = 3'd3;
  localparam logic [2:0] LED_OFF_PERIOD  = 3'd4;
  localparam logic [2:0] LED_OFF_BRIGHT  = 3'd5;

  typedef enum logic [1:0] {
    BLINK_OFF       = 2'd0,
    BLINK_ON_PHASE  = 2'd1,
    BLINK_OFF_PHASE = 2'd2
  } blink_state_e;

endpackage

// File: rtl/led_bus_if.sv
// Address/strobe half of the shared microprocessor bus; the tristate data lines stay a plain inout.
interface led_bus_if;
  import led_bus_pkg::*;

  logic [LED_BUS_W-1:0] BUS_ADDR;
  logic                 BUS_WE;

  modport master (output BUS_ADDR, output BUS_WE);
  modport slave  (input BUS_ADDR, input BUS_WE);
endinterface

// File: rtl/led_blink_timer.sv
// Blink timebase: tick prescaler, tick counter and the OFF / ON_PHASE / OFF_PHASE FSM.
module led_blink_timer
  import led_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV = LED_TICK_DIV_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [LED_PERIOD_W-1:0] period,
  input  logic                    period_wr,
  output logic                    phase
);

  localparam int unsigned     DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  blink_state_e            state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [LED_PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                    tick_c;

  assign tick_c = (div_q == DIV_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= BLINK_OFF;
      div_q      <= '0;
      tick_cnt_q <= '0;
      phase      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      phase      <= (state_d != BLINK_OFF_PHASE);
    end
  end

  // A PERIOD write restarts the timebase and overrides any toggle in the same cycle.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    div_d      = tick_c ? '0 : div_q + DIV_W'(1);
    if (state_q != BLINK_OFF && tick_c) begin
      if (tick_cnt_q == period - LED_PERIOD_W'(1)) begin
        tick_cnt_d = '0;
        state_d    = (state_q == BLINK_ON_PHASE) ? BLINK_OFF_PHASE : BLINK_ON_PHASE;
      end else begin
        tick_cnt_d = tick_cnt_q + LED_PERIOD_W'(1);
      end
    end
    if (period_wr) begin
      div_d      = '0;
      tick_cnt_d = '0;
      state_d    = (period != '0) ? BLINK_ON_PHASE : BLINK_OFF;
    end
  end

endmodule

// File: rtl/led_bus_ctrl.sv
// Memory-mapped LED controller (8-byte window) with readback, blink mask and blink period.
// Define LED_PWM_EN to add the BRIGHT register and 16-cycle PWM gating of the LEDs.
module led_bus_ctrl
  import led_bus_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hC0,
  parameter int unsigned NUM_LEDS  = 16,
  parameter int unsigned TICK_DIV  = LED_TICK_DIV_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  led_bus_if.slave             bus,
  inout  wire  [7:0]           BUS_DATA,
  output logic [NUM_LEDS-1:0]  LED_OUT
);

  localparam logic [15:0] LED_MASK = 16'((32'd1 << NUM_LEDS) - 32'd1);

  logic [2:0]          off_c;
  logic                in_win_c, wr_c, rd_c, period_wr_c, pwm_on_c, phase;
  logic [15:0]         led_q, blink_q;
  logic [7:0]          period_q, period_c, rd_mux_c, rd_data;
  logic                rd_en;
  logic [NUM_LEDS-1:0] led_next_c;

  assign off_c       = bus.BUS_ADDR[2:0];
  assign in_win_c    = (bus.BUS_ADDR[7:3] == BASE_ADDR[7:3]);
  assign wr_c        = in_win_c && bus.BUS_WE;
  assign rd_c        = in_win_c && !bus.BUS_WE;
  assign period_wr_c = wr_c && (off_c == LED_OFF_PERIOD);
  assign period_c    = period_wr_c ? BUS_DATA : period_q;

  // Released as soon as the strobe goes high so the block never fights a writer.
  assign BUS_DATA = (rd_en && !bus.BUS_WE) ? rd_data : 8'hzz;

  led_blink_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .period    (period_c),
    .period_wr (period_wr_c),
    .phase     (phase)
  );

`ifdef LED_PWM_EN
  logic [3:0] bright_q, pwm_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bright_q  <= 4'hF;
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      if (wr_c && off_c == LED_OFF_BRIGHT) bright_q <= BUS_DATA[3:0];
    end
  end

  assign pwm_on_c = (bright_q == 4'hF) || (pwm_cnt_q < bright_q);
`else
  assign pwm_on_c = 1'b1;
`endif

  always_comb begin
    rd_mux_c = '0;
    case (off_c)
      LED_OFF_LED_L:   rd_mux_c = led_q[7:0];
      LED_OFF_LED_H:   rd_mux_c = led_q[15:8];
      LED_OFF_BLINK_L: rd_mux_c = blink_q[7:0];
      LED_OFF_BLINK_H: rd_mux_c = blink_q[15:8];
      LED_OFF_PERIOD:  rd_mux_c = period_q;
`ifdef LED_PWM_EN
      LED_OFF_BRIGHT:  rd_mux_c = {4'h0, bright_q};
`endif
      default:         rd_mux_c = '0;
    endcase
  end

  assign led_next_c = led_q[NUM_LEDS-1:0]
                    & (~blink_q[NUM_LEDS-1:0] | {NUM_LEDS{phase}})
                    & {NUM_LEDS{pwm_on_c}};

  // Bits at or above NUM_LEDS are masked to constant zero on write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      led_q    <= '0;
      blink_q  <= '0;
      period_q <= '0;
      rd_en    <= 1'b0;
      rd_data  <= '0;
      LED_OUT  <= '0;
    end else begin
      rd_en   <= rd_c;
      rd_data <= rd_mux_c;
      LED_OUT <= led_next_c;
      if (wr_c) begin
        case (off_c)
          LED_OFF_LED_L:   led_q[7:0]    <= BUS_DATA & LED_MASK[7:0];
          LED_OFF_LED_H:   led_q[15:8]   <= BUS_DATA & LED_MASK[15:8];
          LED_OFF_BLINK_L: blink_q[7:0]  <= BUS_DATA & LED_MASK[7:0];
          LED_OFF_BLINK_H: blink_q[15:8] <= BUS_DATA & LED_MASK[15:8];
          LED_OFF_PERIOD:  period_q      <= BUS_DATA;
          default:         ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_bus_ctrl.sv
// Directed bench for led_bus_ctrl: a 16-LED instance at 8'hC0 and a 4-LED instance at 8'h40 share one bus.
module tb_led_bus_ctrl;

  localparam logic [7:0] IDLE_ADDR = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tb_wdata;
  logic        tb_oe;
  wire  [7:0]  bus_data;
  logic [15:0] led_w;
  logic [3:0]  led_n;
  logic [7:0]  rd;
  int          checks = 0;
  int          errors = 0;
  int          hi_cnt;

  always #5 clk = ~clk;

  led_bus_if bus ();

  // Released bus floats high, so any value other than 8'hFF while idle means someone drives it.
  pullup (bus_data);
  assign bus_data = tb_oe ? tb_wdata : 8'hzz;

  led_bus_ctrl #(.BASE_ADDR(8'hC0), .NUM_LEDS(16), .TICK_DIV(4)) dut (
    .CLK(clk), .RESET(rst), .bus(bus), .BUS_DATA(bus_data), .LED_OUT(led_w)
  );

  led_bus_ctrl #(.BASE_ADDR(8'h40), .NUM_LEDS(4), .TICK_DIV(4)) dut_n (
    .CLK(clk), .RESET(rst), .bus(bus), .BUS_DATA(bus_data), .LED_OUT(led_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b1;
    tb_wdata     = d;
    tb_oe        = 1'b1;
    @(negedge clk);
    tb_oe        = 1'b0;
    bus.BUS_WE   = 1'b0;
    bus.BUS_ADDR = IDLE_ADDR;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b0;
    @(negedge clk);
    d            = bus_data;
    bus.BUS_ADDR = IDLE_ADDR;
  endtask

  initial begin
    rst          = 1'b1;
    tb_oe        = 1'b0;
    tb_wdata     = '0;
    bus.BUS_ADDR = IDLE_ADDR;
    bus.BUS_WE   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_led", 32'(led_w), 32'h0);
    check_eq("rst_led_n", 32'(led_n), 32'h0);
    check_eq("rst_bus_z", 32'(bus_data), 32'hFF);
    rst = 1'b0;
`ifdef LED_PWM_EN
    bus_read(8'hC5, rd); check_eq("rst_bright", 32'(rd), 32'h0F);
`else
    bus_read(8'hC5, rd); check_eq("rst_bright", 32'(rd), 32'h00);
`endif

    // Write then readback, with two-stage output latency
    bus_write(8'hC0, 8'hA5);
    bus_write(8'hC1, 8'h3C);
    check_eq("led_lat", 32'(led_w), 32'h00A5);
    @(negedge clk);
    check_eq("led_3ca5", 32'(led_w), 32'h3CA5);
    bus_read(8'hC0, rd); check_eq("rd_led_l", 32'(rd), 32'hA5);
    bus_read(8'hC1, rd); check_eq("rd_led_h", 32'(rd), 32'h3C);
    bus_read(8'hC6, rd); check_eq("rd_rsvd", 32'(rd), 32'h00);

    // Narrow instance: only 4 LEDs stored
    bus_write(8'h40, 8'hFF);
    bus_write(8'h41, 8'hFF);
    bus_read(8'h40, rd); check_eq("n_rd_l", 32'(rd), 32'h0F);
    bus_read(8'h41, rd); check_eq("n_rd_h", 32'(rd), 32'h00);
    check_eq("n_led", 32'(led_n), 32'hF);
    check_eq("n_no_alias", 32'(led_w), 32'h3CA5);

    // Blink: PERIOD=3, TICK_DIV=4 -> 12 cycles per phase
    bus_write(8'hC0, 8'hFF);
    bus_write(8'hC1, 8'h00);
    bus_write(8'hC2, 8'h0F);
    bus_write(8'hC3, 8'h00);
    @(negedge clk);
    check_eq("blink_idle", 32'(led_w), 32'h00FF);
    bus_write(8'hC4, 8'h03);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      check_eq($sformatf("blink_k%0d", k), 32'(led_w),
               (((k - 1) / 12) % 2 == 0) ? 32'h00FF : 32'h00F0);
    end
    bus_read(8'hC4, rd); check_eq("rd_period", 32'(rd), 32'h03);

    // Rewriting the same PERIOD restarts the phase count
    bus_write(8'hC4, 8'h03);
    repeat (5) @(negedge clk);
    bus_write(8'hC4, 8'h03);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check_eq($sformatf("restart_k%0d", k), 32'(led_w), (k <= 12) ? 32'h00FF : 32'h00F0);
    end

    // PERIOD=0 stops blinking
    bus_write(8'hC4, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check_eq($sformatf("stop_k%0d", k), 32'(led_w), 32'h00FF);
    end

    // No drive while BUS_WE is high, even straight after a read
    @(negedge clk);
    bus.BUS_ADDR = 8'hC4;
    bus.BUS_WE   = 1'b0;
    @(negedge clk);
    check_eq("rd_period0", 32'(bus_data), 32'h00);
    bus.BUS_WE = 1'b1;
    #1;
    check_eq("we_no_drive", 32'(bus_data), 32'hFF);
    @(negedge clk);
    check_eq("we_no_drive2", 32'(bus_data), 32'hFF);
    bus.BUS_WE   = 1'b0;
    bus.BUS_ADDR = 8'hB0;
    @(negedge clk);
    check_eq("out_win_rd", 32'(bus_data), 32'hFF);
    @(negedge clk);
    check_eq("out_win_rd2", 32'(bus_data), 32'hFF);
    bus.BUS_ADDR = IDLE_ADDR;

    // Asynchronous reset in the middle of a read
    @(negedge clk);
    bus.BUS_ADDR = 8'hC2;
    @(negedge clk);
    check_eq("rd_blink_l", 32'(bus_data), 32'h0F);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_bus_z", 32'(bus_data), 32'hFF);
    check_eq("arst_led", 32'(led_w), 32'h0);
    check_eq("arst_led_n", 32'(led_n), 32'h0);
    @(negedge clk);
    rst          = 1'b0;
    bus.BUS_ADDR = IDLE_ADDR;
    bus_read(8'hC0, rd); check_eq("post_rst_led", 32'(rd), 32'h00);
    bus_read(8'hC4, rd); check_eq("post_rst_period", 32'(rd), 32'h00);
    bus_read(8'h40, rd); check_eq("post_rst_n", 32'(rd), 32'h00);
`ifdef LED_PWM_EN
    bus_read(8'hC5, rd); check_eq("post_rst_bright", 32'(rd), 32'h0F);

    // PWM: BRIGHT=F full on, 4 -> 4/16, 0 -> off
    bus_write(8'hC0, 8'h01);
    @(negedge clk);
    check_eq("pwm_full", 32'(led_w), 32'h0001);
    bus_write(8'hC5, 8'h04);
    bus_read(8'hC5, rd); check_eq("rd_bright", 32'(rd), 32'h04);
    hi_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (led_w[0]) hi_cnt++;
    end
    check_eq("pwm_4of16", 32'(hi_cnt), 32'd8);
    bus_write(8'hC5, 8'h00);
    @(negedge clk);
    hi_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (led_w[0]) hi_cnt++;
    end
    check_eq("pwm_zero", 32'(hi_cnt), 32'd0);
`else
    bus_write(8'hC5, 8'h04);
    bus_read(8'hC5, rd); check_eq("bright_absent", 32'(rd), 32'h00);
    bus_write(8'hC0, 8'h01);
    @(negedge clk);
    check_eq("no_pwm_led", 32'(led_w), 32'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
